// File: rtl/ham_wt_sub.sv
// Byte-serial Hamming-weight counter that records the absolute bit index of each '1' (first 31 kept).
// Latency: one clock from sampling edge to outputs; no backpressure, one byte accepted per clock when pkt_starts is low.
module ham_wt_sub #(
   parameter int DATA_W   = 8,
   parameter int MAX_ONES = 31,
   parameter int IDX_W    = 10
) (
   input  logic                        clk,
   input  logic                        clear,
   input  logic                        pkt_starts,
   input  logic [DATA_W-1:0]           bin_data,
   output logic [4:0]                  ham_wt,
   output logic [MAX_ONES*IDX_W-1:0]   locn_ones
);

   localparam int WT_W      = $clog2(MAX_ONES + 1);
   localparam int BIT_W     = $clog2(DATA_W);
   localparam int BYTES_MAX = (1 << IDX_W) / DATA_W;
   localparam int CNT_W     = $clog2(BYTES_MAX + 1);

   localparam logic [WT_W:0]    WT_LIM  = (WT_W + 1)'(MAX_ONES);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(BYTES_MAX);

   logic [WT_W-1:0]                        wt_q, wt_d;
   logic [CNT_W-1:0]                       cnt_q, cnt_d;
   logic [MAX_ONES-1:0][IDX_W-1:0]         locn_q, locn_d;
   logic [WT_W:0]                          pos;

   // pos walks the slot index across the byte, so each set bit lands at ham_wt + prefix count
   always_comb begin
      wt_d   = wt_q;
      cnt_d  = cnt_q;
      locn_d = locn_q;
      pos    = {1'b0, wt_q};
      if (pkt_starts) begin
         wt_d   = '0;
         cnt_d  = '0;
         locn_d = '0;
      end else if (cnt_q < CNT_LIM) begin
         cnt_d = cnt_q + CNT_W'(1);
         for (int i = 0; i < DATA_W; i++) begin
            if (bin_data[i]) begin
               if (pos < WT_LIM) begin
                  locn_d[pos[WT_W-1:0]] = {cnt_q[IDX_W-BIT_W-1:0], BIT_W'(i)};
               end
               pos = pos + (WT_W + 1)'(1);
            end
         end
         wt_d = (pos > WT_LIM) ? WT_LIM[WT_W-1:0] : pos[WT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         wt_q   <= '0;
         cnt_q  <= '0;
         locn_q <= '0;
      end else begin
         wt_q   <= wt_d;
         cnt_q  <= cnt_d;
         locn_q <= locn_d;
      end
   end

   assign ham_wt    = wt_q;
   assign locn_ones = locn_q;

endmodule

// File: tb/tb_ham_wt_sub.sv
// Randomised and directed bench for ham_wt_sub against a list-based reference model.
module tb_ham_wt_sub;

   logic         clk = 1'b0;
   logic         clear;
   logic         pkt_starts;
   logic [7:0]   bin_data;
   logic [4:0]   ham_wt;
   logic [309:0] locn_ones;

   int n_vec = 0;
   int n_err = 0;

   int m_loc[31];
   int m_wt;
   int m_bytes;

   ham_wt_sub dut (
      .clk        (clk),
      .clear      (clear),
      .pkt_starts (pkt_starts),
      .bin_data   (bin_data),
      .ham_wt     (ham_wt),
      .locn_ones  (locn_ones)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [309:0] got, input logic [309:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] slot(input int k);
      return locn_ones[k*10 +: 10];
   endfunction

   task automatic model_reset();
      m_wt    = 0;
      m_bytes = 0;
      for (int k = 0; k < 31; k++) m_loc[k] = 0;
   endtask

   task automatic model_step(input logic s, input logic [7:0] d);
      if (s) begin
         model_reset();
      end else if (m_bytes < 128) begin
         for (int i = 0; i < 8; i++) begin
            if (d[i] && m_wt < 31) begin
               m_loc[m_wt] = m_bytes * 8 + i;
               m_wt++;
            end
         end
         m_bytes++;
      end
   endtask

   function automatic logic [309:0] exp_locn();
      logic [309:0] v = '0;
      for (int k = 0; k < 31; k++) v[k*10 +: 10] = 10'(m_loc[k]);
      return v;
   endfunction

   task automatic step(input logic s, input logic [7:0] d);
      pkt_starts = s;
      bin_data   = d;
      @(posedge clk);
      #1;
      model_step(s, d);
      check("ham_wt", 310'(ham_wt), 310'(m_wt));
      check("locn_ones", locn_ones, exp_locn());
   endtask

   initial begin
      clear      = 1'b1;
      pkt_starts = 1'($urandom);
      bin_data   = 8'($urandom);
      model_reset();
      // asynchronous reset before the first edge
      #2 clear = 1'b0;
      #1;
      check("rst_wt", 310'(ham_wt), 310'(0));
      check("rst_locn", locn_ones, 310'(0));
      @(posedge clk);
      #1;
      check("rst_hold_wt", 310'(ham_wt), 310'(0));
      clear = 1'b1;

      // basic packet
      step(1'b1, 8'h00);
      step(1'b1, 8'h00);
      step(1'b0, 8'hC7);
      check("basic_wt1", 310'(ham_wt), 310'(5));
      check("basic_s4", 310'(slot(4)), 310'(7));
      step(1'b0, 8'hA8);
      check("basic_wt2", 310'(ham_wt), 310'(8));
      check("basic_s5", 310'(slot(5)), 310'(11));
      check("basic_s7", 310'(slot(7)), 310'(15));

      // saturation
      step(1'b1, 8'h00);
      for (int b = 0; b < 4; b++) step(1'b0, 8'hFF);
      check("sat_wt", 310'(ham_wt), 310'(31));
      check("sat_s30", 310'(slot(30)), 310'(30));
      step(1'b0, 8'hFF);
      check("sat_hold", 310'(ham_wt), 310'(31));

      // restart mid-packet
      step(1'b1, 8'hFF);
      check("rs_wt0", 310'(ham_wt), 310'(0));
      step(1'b0, 8'h01);
      check("rs_wt1", 310'(ham_wt), 310'(1));
      check("rs_s0", 310'(slot(0)), 310'(0));

      // packet length limit
      step(1'b1, 8'h00);
      for (int b = 0; b < 127; b++) step(1'b0, 8'h00);
      step(1'b0, 8'h80);
      check("len_s0", 310'(slot(0)), 310'(1023));
      step(1'b0, 8'hFF);
      check("len_wt", 310'(ham_wt), 310'(1));

      // zero byte
      step(1'b1, 8'h00);
      step(1'b0, 8'h02);
      step(1'b0, 8'h00);
      check("zb_s0", 310'(slot(0)), 310'(1));
      step(1'b0, 8'h01);
      check("zb_s1", 310'(slot(1)), 310'(16));

      // randomised traffic with occasional restarts and mid-packet clears
      for (int n = 0; n < 1500; n++) begin
         logic s;
         logic [7:0] d;
         s = ($urandom_range(0, (n < 700) ? 15 : 150) == 0);
         case ($urandom_range(0, 3))
            0:       d = 8'h00;
            1:       d = 8'(1 << $urandom_range(0, 7));
            default: d = 8'($urandom);
         endcase
         step(s, d);
         if ($urandom_range(0, 199) == 0) begin
            clear = 1'b0;
            #2;
            model_reset();
            check("clr_wt", 310'(ham_wt), 310'(0));
            check("clr_locn", locn_ones, 310'(0));
            clear = 1'b1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ham_wt_sub.md
Name: ham_wt_sub

Overview:
Streaming Hamming-weight and one-location extractor for a byte-serial packet. It accepts one byte per clock after a packet-start marker. It accumulates the count of '1' bits across the packet and records the absolute bit index of each '1' in a packed location list. It sits downstream of a byte deserializer and feeds packet-level error/weight analysis logic.

Parameters:
- DATA_W, 8, input byte width (fixed; listed for documentation).
- MAX_ONES, 31, number of location slots and saturation value of ham_wt.
- IDX_W, 10, width of each recorded bit index (packet up to 1024 bits = 128 bytes).

Ports:
- clk  input  1  system clock, rising-edge.
- clear  input  1  asynchronous active-low reset.
- pkt_starts  input  1  high = packet start / restart; low = accept bin_data this cycle.
- bin_data  input  8  packet byte; bin_data[i] is bit i of the current byte.
- ham_wt  output  5  running count of ones in the packet, saturating at 31.
- locn_ones  output  310  31 slots × 10 bits; slot k = locn_ones[10k+9:10k] = bit index of the (k+1)-th one.

Behaviour:
- One clock; reset is asynchronous and active-low (clear), clock is clk.
- Reset (clear=0): ham_wt=0, locn_ones=0, internal byte counter=0. This is asynchronous and takes priority over everything.
- pkt_starts=1 at a rising edge: synchronously clears ham_wt, locn_ones and the byte counter to 0. bin_data is ignored that cycle.
- pkt_starts=0 at a rising edge with byte counter < 128:
  - The byte is sampled.
  - Each set bit bin_data[i] gets absolute index byte_cnt*8+i.
  - Set bits are appended in ascending i order into consecutive free slots starting at slot ham_wt.
  - ham_wt increments by popcount(bin_data).
  - The byte counter increments.
- Latency: outputs are registered and reflect a byte one clock after the edge that sampled it.
- Multiple ones per byte (0..8) are inserted in the same cycle. Slot position = current ham_wt + number of lower set bits in the byte (prefix count).
- Saturation: ham_wt never exceeds 31. Ones that would land in slot ≥31 are dropped. Further bytes still advance the byte counter.
- Byte counter reaching 128: further bytes are ignored until pkt_starts or reset. ham_wt and locn_ones are held.
- Unused slots read 0. Slot validity is determined solely by k < ham_wt, so index 0 is unambiguous.
- Byte 0x00: only the byte counter advances.
- pkt_starts high for several cycles: state held at zero throughout.
- Asserting clear mid-packet: immediate zero. Accumulation resumes only after clear deasserts and data is presented with pkt_starts=0.

Test Plan:
- Reset: clear=0 with random inputs → ham_wt=0, locn_ones=0 asynchronously, before any clock edge.
- Basic packet: clear=1, pkt_starts=1 for 2 clocks, then pkt_starts=0, bin_data=8'hC7, then 8'hA8.
  - After the first byte: ham_wt=5, slots 0..4 = 0,1,2,6,7.
  - After the second byte: ham_wt=8, slots 5..7 = 11,13,15.
- Saturation: four bytes of 8'hFF → ham_wt=31 after byte 4 (32 ones offered), slots 0..30 = 0..30, slot 31's one dropped; a further 8'hFF leaves ham_wt=31.
- Restart: mid-packet pkt_starts=1 for one clock → ham_wt=0, locn_ones=0. The next byte 8'h01 gives ham_wt=1, slot0=0 (byte counter restarted).
- Packet length limit: 127 bytes of 8'h00, then byte 128 = 8'h80 → ham_wt=1, slot0=1023. A 129th byte 8'hFF is ignored (ham_wt stays 1).
- Zero byte: 8'h00 after 8'h02 → ham_wt=1, slot0=1. The next byte 8'h01 records index 16.
